fault_alarm_ctrl: RTL and testbench
===================================

Name: fault_alarm_ctrl

Overview:
Controller for the fault-attack invariant monitors. It holds the monitors' configuration (protected address, enable) behind a machine-mode-only register port with a sticky lock. It collects and latches monitor alarms, interrupts the core, and escalates to a sticky halt request after a programmable number of alarm events. It sits between the Ibex core's privileged software and the bank of combinational monitors.

Parameters:
NUM_MON, 2, number of monitor alarm inputs
CNT_W, 4, width of the saturating alarm event counter
ACK_TIMEOUT, 64, cycles allowed for irq acknowledge (only used with optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
priv_lvl_i  in  2  current privilege level from cs_registers (2'b11 = M-mode)
cfg_we_i  in  1  config write strobe, single cycle
cfg_addr_i  in  2  config register index
cfg_wdata_i  in  32  config write data
cfg_rdata_o  out  32  config read data, combinational on cfg_addr_i
alarm_i  in  NUM_MON  alarm outputs of the monitors
secret_addr_o  out  32  protected address driven to monitors
mon_en_o  out  1  monitor enable, gates alarm_i
irq_o  out  1  alarm interrupt to core
irq_ack_i  in  1  interrupt acknowledge, single-cycle pulse
halt_req_o  out  1  sticky escalation / halt request
alarm_cnt_o  out  CNT_W  alarm event count

Behaviour:
- Registers: 0 SECRET_ADDR[31:0]; 1 CTRL {bit1 lock, bit0 mon_en}; 2 THRESH[CNT_W-1:0]; 3 STATUS (read-only) {[NUM_MON+CNT_W+1:CNT_W+2] src mask, [CNT_W+1:2] count, [1:0] state}.
- Write is accepted only when cfg_we_i && priv_lvl_i==2'b11 && !lock. Writes to STATUS are ignored. The lock bit is set-only and clears only on reset. A write carrying lock=1 updates mon_en in the same write.
- Reset values: all registers 0, FSM IDLE, irq_o=0, halt_req_o=0, alarm_cnt_o=0, mon_en_o=0, secret_addr_o=0.
- The FSM is registered. State encoding: IDLE=0, ARMED=1, ALERT=2, LOCKDOWN=3.
- IDLE: alarm_i is ignored. The FSM moves to ARMED on the cycle after mon_en becomes 1.
- ARMED:
  - Any (alarm_i != 0) moves to ALERT next cycle, ORs alarm_i into src, and increments the count.
  - Clearing mon_en returns to IDLE.
- ALERT:
  - irq_o=1 (registered, asserted the cycle after the alarm).
  - Each cycle with an alarm ORs into src and increments the count.
  - If THRESH!=0 and the updated count >= THRESH, the FSM goes to LOCKDOWN immediately.
  - Otherwise irq_ack_i returns to ARMED and clears src; the count is kept.
  - Writes to mon_en are ignored while in ALERT.
- LOCKDOWN: halt_req_o=1 and irq_o=0. The FSM stays here until reset, ignoring all inputs.
- Count saturates at 2^CNT_W-1; it never wraps. THRESH=0 disables escalation.
- Alarm and ack in the same cycle: the increment is applied first and the threshold is compared with the new count. If the threshold is not reached, the ack is honoured, the FSM returns to ARMED, and the new alarm's src bits are retained. This alarm is an event already counted, so it does not re-enter ALERT.
- A multi-cycle alarm counts once per cycle that it is asserted.
- Asynchronous reset mid-ALERT or mid-LOCKDOWN returns immediately to the reset values.

Optional Feature:
FAULT_ALARM_TIMEOUT_EN
- Defined: a timer counts cycles spent in ALERT. If it reaches ACK_TIMEOUT without irq_ack_i, the FSM enters LOCKDOWN. The timer clears on entering ALERT.
- Undefined: no timer; ALERT waits indefinitely for irq_ack_i.

Decomposition:
- Shared package fault_mon_pkg holds:
  - the state enum alarm_state_e;
  - register index constants (REG_SECRET, REG_CTRL, REG_THRESH, REG_STATUS);
  - the PRIV_LVL_M constant.
- One sub-module, fault_alarm_cfg_regs, implements the register file, privilege/lock gating and the read mux. The FSM and counter stay in the top module.

Test Plan:
- M-mode write SECRET_ADDR=0x0000_1000, then CTRL=0x1 -> secret_addr_o=0x1000, mon_en_o=1, state ARMED after 1 cycle.
- priv_lvl_i=2'b00 write SECRET_ADDR=0xDEAD_BEEF -> secret_addr_o unchanged. Write CTRL=0x3, then M-mode write THRESH=5 -> THRESH unchanged (locked).
- ARMED, THRESH=3, alarm_i=2'b01 one cycle -> irq_o=1 next cycle, count=1, src=01; irq_ack_i -> ARMED, irq_o=0.
- THRESH=3, three separated alarm+ack events -> third alarm gives LOCKDOWN, halt_req_o=1, irq_o=0; later inputs have no effect until rst_i.
- THRESH=0, alarm_i held for 20 cycles with CNT_W=4 -> count saturates at 15, no LOCKDOWN. Same-cycle alarm and ack in ALERT -> count+1, FSM returns to ARMED.
- With FAULT_ALARM_TIMEOUT_EN and ACK_TIMEOUT=64, no ack -> LOCKDOWN on the 64th ALERT cycle. Without the macro -> still ALERT after 1000 cycles.

Source files
------------

// File: rtl/fault_mon_pkg.sv
// Shared types and constants for the fault-attack alarm controller and its register file.
package fault_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_ALERT    = 2'd2,
        ST_LOCKDOWN = 2'd3
    } alarm_state_e;

    localparam logic [1:0] REG_SECRET = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_THRESH = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [1:0] PRIV_LVL_M = 2'b11;

endpackage

// File: rtl/fault_alarm_cfg_regs.sv
// Machine-mode-only configuration registers with a sticky lock and a combinational read mux.
module fault_alarm_cfg_regs
    import fault_mon_pkg::*;
#(
    parameter int NUM_MON = 2,
    parameter int CNT_W   = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         priv_lvl_i,
    input  logic               cfg_we_i,
    input  logic [1:0]         cfg_addr_i,
    input  logic [31:0]        cfg_wdata_i,
    output logic [31:0]        cfg_rdata_o,
    input  logic               in_alert_i,
    input  logic [NUM_MON-1:0] status_src_i,
    input  logic [CNT_W-1:0]   status_cnt_i,
    input  alarm_state_e       status_state_i,
    output logic [31:0]        secret_addr_o,
    output logic               mon_en_o,
    output logic [CNT_W-1:0]   thresh_o
);

    logic [31:0]      secret_q, secret_d;
    logic             mon_en_q, mon_en_d;
    logic             lock_q, lock_d;
    logic [CNT_W-1:0] thresh_q, thresh_d;
    logic             wr_ok;

    assign wr_ok = cfg_we_i && (priv_lvl_i == PRIV_LVL_M) && !lock_q;

    always_comb begin
        secret_d = secret_q;
        mon_en_d = mon_en_q;
        lock_d   = lock_q;
        thresh_d = thresh_q;
        if (wr_ok) begin
            case (cfg_addr_i)
                REG_SECRET: secret_d = cfg_wdata_i;
                REG_CTRL: begin
                    // Lock can only be set; enable is frozen while an alert is pending.
                    lock_d = lock_q | cfg_wdata_i[1];
                    if (!in_alert_i) mon_en_d = cfg_wdata_i[0];
                end
                REG_THRESH: thresh_d = cfg_wdata_i[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            secret_q <= '0;
            mon_en_q <= 1'b0;
            lock_q   <= 1'b0;
            thresh_q <= '0;
        end else begin
            secret_q <= secret_d;
            mon_en_q <= mon_en_d;
            lock_q   <= lock_d;
            thresh_q <= thresh_d;
        end
    end

    always_comb begin
        cfg_rdata_o = '0;
        case (cfg_addr_i)
            REG_SECRET: cfg_rdata_o = secret_q;
            REG_CTRL:   cfg_rdata_o[1:0] = {lock_q, mon_en_q};
            REG_THRESH: cfg_rdata_o[CNT_W-1:0] = thresh_q;
            default:    cfg_rdata_o[NUM_MON+CNT_W+1:0] = {status_src_i, status_cnt_i, status_state_i};
        endcase
    end

    assign secret_addr_o = secret_q;
    assign mon_en_o      = mon_en_q;
    assign thresh_o      = thresh_q;

endmodule

// File: rtl/fault_alarm_ctrl.sv
// Alarm collection FSM with saturating event counter and sticky halt escalation.
// Optional ALERT acknowledge timeout is enabled by defining FAULT_ALARM_TIMEOUT_EN.
module fault_alarm_ctrl
    import fault_mon_pkg::*;
#(
    parameter int NUM_MON     = 2,
    parameter int CNT_W       = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         priv_lvl_i,
    input  logic               cfg_we_i,
    input  logic [1:0]         cfg_addr_i,
    input  logic [31:0]        cfg_wdata_i,
    output logic [31:0]        cfg_rdata_o,
    input  logic [NUM_MON-1:0] alarm_i,
    output logic [31:0]        secret_addr_o,
    output logic               mon_en_o,
    output logic               irq_o,
    input  logic               irq_ack_i,
    output logic               halt_req_o,
    output logic [CNT_W-1:0]   alarm_cnt_o
);

    alarm_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc, cnt_new;
    logic [NUM_MON-1:0] src_q, src_d, alarm_eff;
    logic [CNT_W-1:0]   thresh;
    logic               mon_en;
    logic               alarm_any;
    logic               thresh_hit;

    fault_alarm_cfg_regs #(
        .NUM_MON(NUM_MON),
        .CNT_W  (CNT_W)
    ) u_cfg_regs (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .priv_lvl_i    (priv_lvl_i),
        .cfg_we_i      (cfg_we_i),
        .cfg_addr_i    (cfg_addr_i),
        .cfg_wdata_i   (cfg_wdata_i),
        .cfg_rdata_o   (cfg_rdata_o),
        .in_alert_i    (state_q == ST_ALERT),
        .status_src_i  (src_q),
        .status_cnt_i  (cnt_q),
        .status_state_i(state_q),
        .secret_addr_o (secret_addr_o),
        .mon_en_o      (mon_en),
        .thresh_o      (thresh)
    );

    assign alarm_eff  = mon_en ? alarm_i : '0;
    assign alarm_any  = |alarm_eff;
    assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign cnt_new    = alarm_any ? cnt_inc : cnt_q;
    assign thresh_hit = (thresh != '0) && (cnt_new >= thresh);

`ifdef FAULT_ALARM_TIMEOUT_EN
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             timeout;

    // Timer is held at zero outside ALERT, so it starts fresh on every entry.
    assign timer_d = (state_q == ST_ALERT) ? timer_q + 1'b1 : '0;
    assign timeout = (timer_q == TMR_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) timer_q <= '0;
        else       timer_q <= timer_d;
    end
`else
    logic timeout;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        case (state_q)
            ST_IDLE: begin
                if (mon_en) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!mon_en) begin
                    state_d = ST_IDLE;
                end else if (alarm_any) begin
                    state_d = ST_ALERT;
                    src_d   = src_q | alarm_eff;
                    cnt_d   = cnt_inc;
                end
            end
            ST_ALERT: begin
                cnt_d = cnt_new;
                src_d = src_q | alarm_eff;
                if (thresh_hit) begin
                    state_d = ST_LOCKDOWN;
                end else if (irq_ack_i) begin
                    // A simultaneous alarm is already counted; keep only its source bits.
                    state_d = ST_ARMED;
                    src_d   = alarm_eff;
                end else if (timeout) begin
                    state_d = ST_LOCKDOWN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
        end
    end

    assign irq_o       = (state_q == ST_ALERT);
    assign halt_req_o  = (state_q == ST_LOCKDOWN);
    assign alarm_cnt_o = cnt_q;
    assign mon_en_o    = mon_en;

endmodule

// File: tb/tb_fault_alarm_ctrl.sv
// Directed self-checking bench for fault_alarm_ctrl (NUM_MON=2, CNT_W=4).
module tb_fault_alarm_ctrl;
    import fault_mon_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  priv_lvl_i = 2'b11;
    logic        cfg_we_i = 1'b0;
    logic [1:0]  cfg_addr_i = 2'd0;
    logic [31:0] cfg_wdata_i = '0;
    logic [31:0] cfg_rdata_o;
    logic [1:0]  alarm_i = '0;
    logic [31:0] secret_addr_o;
    logic        mon_en_o;
    logic        irq_o;
    logic        irq_ack_i = 1'b0;
    logic        halt_req_o;
    logic [3:0]  alarm_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] rd_val;

    fault_alarm_ctrl #(.NUM_MON(2), .CNT_W(4), .ACK_TIMEOUT(64)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .priv_lvl_i   (priv_lvl_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .cfg_rdata_o  (cfg_rdata_o),
        .alarm_i      (alarm_i),
        .secret_addr_o(secret_addr_o),
        .mon_en_o     (mon_en_o),
        .irq_o        (irq_o),
        .irq_ack_i    (irq_ack_i),
        .halt_req_o   (halt_req_o),
        .alarm_cnt_o  (alarm_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got=0x%08h exp=0x%08h ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [1:0] p);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = a;
        cfg_wdata_i = d;
        priv_lvl_i  = p;
        tick();
        cfg_we_i    = 1'b0;
        priv_lvl_i  = PRIV_LVL_M;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        cfg_addr_i = a;
        #1;
        d = cfg_rdata_o;
    endtask

    task automatic do_reset();
        rst_i     = 1'b1;
        alarm_i   = '0;
        irq_ack_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    // STATUS layout: src[7:6], count[5:2], state[1:0]
    function automatic logic [31:0] status(input logic [1:0] src, input logic [3:0] cnt, input logic [1:0] st);
        return {24'd0, src, cnt, st};
    endfunction

    initial begin
        do_reset();

        // Reset state
        check("rst_secret", secret_addr_o, 32'h0);
        check("rst_mon_en", {31'd0, mon_en_o}, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check("rst_halt", {31'd0, halt_req_o}, 32'd0);
        check("rst_cnt", {28'd0, alarm_cnt_o}, 32'd0);
        rd(REG_STATUS, rd_val);
        check("rst_status", rd_val, 32'd0);

        // Configuration and privilege gating
        wr(REG_SECRET, 32'h0000_1000, 2'b11);
        check("secret_m", secret_addr_o, 32'h0000_1000);
        wr(REG_SECRET, 32'hDEAD_BEEF, 2'b00);
        check("secret_umode", secret_addr_o, 32'h0000_1000);
        wr(REG_THRESH, 32'd3, 2'b11);
        rd(REG_THRESH, rd_val);
        check("thresh_rd", rd_val, 32'd3);
        wr(REG_CTRL, 32'h1, 2'b11);
        check("mon_en_set", {31'd0, mon_en_o}, 32'd1);
        rd(REG_STATUS, rd_val);
        check("still_idle", rd_val, status(2'b00, 4'd0, 2'd0));
        tick();
        rd(REG_STATUS, rd_val);
        check("armed", rd_val, status(2'b00, 4'd0, 2'd1));

        // Event 1: single-cycle alarm, mon_en write ignored in ALERT, ack
        alarm_i = 2'b01;
        tick();
        alarm_i = 2'b00;
        check("ev1_irq", {31'd0, irq_o}, 32'd1);
        rd(REG_STATUS, rd_val);
        check("ev1_status", rd_val, status(2'b01, 4'd1, 2'd2));
        wr(REG_CTRL, 32'h0, 2'b11);
        check("alert_en_keep", {31'd0, mon_en_o}, 32'd1);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        check("ev1_ack_irq", {31'd0, irq_o}, 32'd0);
        rd(REG_STATUS, rd_val);
        check("ev1_ack_st", rd_val, status(2'b00, 4'd1, 2'd1));

        // Event 2
        alarm_i = 2'b10;
        tick();
        alarm_i = 2'b00;
        rd(REG_STATUS, rd_val);
        check("ev2_status", rd_val, status(2'b10, 4'd2, 2'd2));
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        rd(REG_STATUS, rd_val);
        check("ev2_ack_st", rd_val, status(2'b00, 4'd2, 2'd1));

        // Event 3 reaches threshold: one ALERT cycle, then LOCKDOWN
        alarm_i = 2'b01;
        tick();
        alarm_i = 2'b00;
        check("ev3_irq", {31'd0, irq_o}, 32'd1);
        check("ev3_cnt", {28'd0, alarm_cnt_o}, 32'd3);
        tick();
        check("lock_halt", {31'd0, halt_req_o}, 32'd1);
        check("lock_irq", {31'd0, irq_o}, 32'd0);
        rd(REG_STATUS, rd_val);
        check("lock_status", rd_val, status(2'b01, 4'd3, 2'd3));
        alarm_i   = 2'b11;
        irq_ack_i = 1'b1;
        repeat (5) tick();
        alarm_i   = 2'b00;
        irq_ack_i = 1'b0;
        check("lock_hold_cnt", {28'd0, alarm_cnt_o}, 32'd3);
        check("lock_hold", {31'd0, halt_req_o}, 32'd1);

        // Asynchronous reset clears immediately, without a clock edge
        #2;
        rst_i = 1'b1;
        #1;
        check("async_halt", {31'd0, halt_req_o}, 32'd0);
        check("async_cnt", {28'd0, alarm_cnt_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        tick();

        // THRESH=0: held alarm saturates the count, no escalation
        wr(REG_CTRL, 32'h1, 2'b11);
        tick();
        alarm_i = 2'b01;
        repeat (20) tick();
        alarm_i = 2'b00;
        check("sat_cnt", {28'd0, alarm_cnt_o}, 32'd15);
        check("sat_nohalt", {31'd0, halt_req_o}, 32'd0);
        rd(REG_STATUS, rd_val);
        check("sat_status", rd_val, status(2'b01, 4'd15, 2'd2));

        // Same-cycle alarm and ack
        do_reset();
        wr(REG_CTRL, 32'h1, 2'b11);
        tick();
        alarm_i = 2'b01;
        tick();
        alarm_i   = 2'b10;
        irq_ack_i = 1'b1;
        tick();
        alarm_i   = 2'b00;
        irq_ack_i = 1'b0;
        rd(REG_STATUS, rd_val);
        check("same_cyc", rd_val, status(2'b10, 4'd2, 2'd1));
        tick();
        rd(REG_STATUS, rd_val);
        check("same_no_realrt", rd_val, status(2'b10, 4'd2, 2'd1));

        // Clearing mon_en in ARMED returns to IDLE; alarms then ignored
        wr(REG_CTRL, 32'h0, 2'b11);
        tick();
        alarm_i = 2'b11;
        tick();
        alarm_i = 2'b00;
        rd(REG_STATUS, rd_val);
        check("idle_ignore", rd_val, status(2'b10, 4'd2, 2'd0));

        // Lock: enable applied with the lock, later writes blocked
        wr(REG_CTRL, 32'h3, 2'b11);
        rd(REG_CTRL, rd_val);
        check("ctrl_locked", rd_val, 32'h3);
        wr(REG_THRESH, 32'd5, 2'b11);
        rd(REG_THRESH, rd_val);
        check("thresh_locked", rd_val, 32'd0);
        wr(REG_CTRL, 32'h0, 2'b11);
        check("en_locked", {31'd0, mon_en_o}, 32'd1);

        // ACK timeout behaviour
        do_reset();
        wr(REG_CTRL, 32'h1, 2'b11);
        tick();
        alarm_i = 2'b01;
        tick();
        alarm_i = 2'b00;
`ifdef FAULT_ALARM_TIMEOUT_EN
        repeat (63) tick();
        check("tmo_pre", {31'd0, irq_o}, 32'd1);
        tick();
        check("tmo_halt", {31'd0, halt_req_o}, 32'd1);
`else
        repeat (1000) tick();
        check("no_tmo_irq", {31'd0, irq_o}, 32'd1);
        check("no_tmo_halt", {31'd0, halt_req_o}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
